// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencing controller: load-use stall insertion, taken-branch flushes,
// memory-busy freeze and saturating stall/flush performance counters.
module decode_hazard_ctrl #(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    LDSTALL = 1'b1
  } state_t;

  localparam logic [2:0] REM_START = 3'(LOAD_LATENCY - 1);

  state_t           st_r;
  state_t           st_nxt_s;
  logic [2:0]       rem_r;
  logic [2:0]       rem_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             hz_s;
  logic             stall_inc_s;
  logic             flush_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Load-use hazard; register 0 is hardwired so it can never carry a dependency.
  always_comb begin
    hz_s = 1'b0;
    if (ex_mem_read && (ex_rt != 5'd0) &&
        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)))) begin
      hz_s = 1'b1;
    end else begin
      hz_s = 1'b0;
    end
  end

  // Control outputs and next state; priority is busy > branch > stall continuation > hazard.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_hold    = 1'b0;
    st_nxt_s     = st_r;
    rem_nxt_s    = rem_r;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;

    if (rst) begin
      st_nxt_s  = RUN;
      rem_nxt_s = 3'd0;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else begin
      case (st_r)
        RUN: begin
          if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc_s  = 1'b1;
          end else if (hz_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc_s  = 1'b1;
            if (LOAD_LATENCY > 1) begin
              st_nxt_s  = LDSTALL;
              rem_nxt_s = REM_START;
            end else begin
              st_nxt_s  = RUN;
              rem_nxt_s = 3'd0;
            end
          end else begin
            st_nxt_s = RUN;
          end
        end
        LDSTALL: begin
          if (mem_branch_taken) begin
            // The stalled instruction is being flushed, so the stall is dropped.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc_s  = 1'b1;
            st_nxt_s     = RUN;
            rem_nxt_s    = 3'd0;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc_s  = 1'b1;
            if (rem_r <= 3'd1) begin
              st_nxt_s  = RUN;
              rem_nxt_s = 3'd0;
            end else begin
              st_nxt_s  = LDSTALL;
              rem_nxt_s = rem_r - 3'd1;
            end
          end
        end
        default: begin
          st_nxt_s  = RUN;
          rem_nxt_s = 3'd0;
        end
      endcase
    end
  end

  // State, remaining-cycle counter and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r        <= RUN;
      rem_r       <= 3'd0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      st_r  <= st_nxt_s;
      rem_r <= rem_nxt_s;
      if (stall_inc_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stalled   = (st_r == LDSTALL);
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed self-checking bench for decode_hazard_ctrl with three parameterisations
// (latency 1, latency 3, and a 4-bit counter instance for saturation).
module tb_decode_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       mem_branch_taken;
  logic       mem_busy;

  logic        a_pc, a_ifw, a_bub, a_iff, a_idf, a_exf, a_hold, a_stl;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_pc, b_ifw, b_bub, b_iff, b_idf, b_exf, b_hold, b_stl;
  logic [15:0] b_scnt, b_fcnt;
  logic        c_pc, c_ifw, c_bub, c_iff, c_idf, c_exf, c_hold, c_stl;
  logic [3:0]  c_scnt, c_fcnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(16)) dut_l1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_busy(mem_busy), .pc_write(a_pc), .if_id_write(a_ifw), .id_ex_bubble(a_bub),
    .if_id_flush(a_iff), .id_ex_flush(a_idf), .ex_mem_flush(a_exf), .pipe_hold(a_hold),
    .stalled(a_stl), .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  decode_hazard_ctrl #(.LOAD_LATENCY(3), .CNT_W(16)) dut_l3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_busy(mem_busy), .pc_write(b_pc), .if_id_write(b_ifw), .id_ex_bubble(b_bub),
    .if_id_flush(b_iff), .id_ex_flush(b_idf), .ex_mem_flush(b_exf), .pipe_hold(b_hold),
    .stalled(b_stl), .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  decode_hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_busy(mem_busy), .pc_write(c_pc), .if_id_write(c_ifw), .id_ex_bubble(c_bub),
    .if_id_flush(c_iff), .id_ex_flush(c_idf), .ex_mem_flush(c_exf), .pipe_hold(c_hold),
    .stalled(c_stl), .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] xrt, input logic br, input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mr;
    ex_rt = xrt; mem_branch_taken = br; mem_busy = busy;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Reset with random inputs: combinational outputs must stay at defaults.
    for (int i = 0; i < 2; i++) begin
      drive(5'($urandom), 5'($urandom), 1'($urandom), 1'b1, 5'd7, 1'($urandom), 1'($urandom));
      check_eq("rst_pc_write", {31'd0, b_pc}, 32'd1);
      check_eq("rst_bubble", {31'd0, b_bub}, 32'd0);
      check_eq("rst_hold", {31'd0, b_hold}, 32'd0);
      tick();
    end
    rst = 1'b0;
    idle();
    check_eq("rst_stalled", {31'd0, b_stl}, 32'd0);
    check_eq("rst_stall_cnt", {16'd0, b_scnt}, 32'd0);
    check_eq("rst_flush_cnt", {16'd0, b_fcnt}, 32'd0);
    check_eq("rst_ctrl", {25'd0, b_pc, b_ifw, b_bub, b_iff, b_idf, b_exf, b_hold}, 32'h40 | 32'h20);

    // Latency 1: single-cycle bubble on rs match.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    check_eq("l1_hz_ctrl", {29'd0, a_pc, a_ifw, a_bub}, 32'd1);
    tick();
    idle();
    check_eq("l1_after_ctrl", {29'd0, a_pc, a_ifw, a_bub}, 32'd6);
    check_eq("l1_stall_cnt", {16'd0, a_scnt}, 32'd1);
    check_eq("l1_stalled", {31'd0, a_stl}, 32'd0);
    drive(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    check_eq("l1_rt_unused", {31'd0, a_bub}, 32'd0);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    check_eq("l1_reg0", {31'd0, a_bub}, 32'd0);
    drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    check_eq("l1_rt_used", {31'd0, a_bub}, 32'd1);

    // Latency 3: rt hazard yields three bubble cycles.
    do_reset();
    drive(5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    check_eq("l3_c1_bubble", {31'd0, b_bub}, 32'd1);
    check_eq("l3_c1_stalled", {31'd0, b_stl}, 32'd0);
    tick();
    idle();
    check_eq("l3_c2_ctrl", {29'd0, b_pc, b_ifw, b_bub}, 32'd1);
    check_eq("l3_c2_stalled", {31'd0, b_stl}, 32'd1);
    tick();
    check_eq("l3_c3_bubble", {31'd0, b_bub}, 32'd1);
    check_eq("l3_c3_stalled", {31'd0, b_stl}, 32'd1);
    tick();
    check_eq("l3_c4_ctrl", {29'd0, b_pc, b_ifw, b_bub}, 32'd6);
    check_eq("l3_c4_stalled", {31'd0, b_stl}, 32'd0);
    check_eq("l3_stall_cnt", {16'd0, b_scnt}, 32'd3);

    // Taken branch wins over a simultaneous hazard.
    do_reset();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    check_eq("br_flushes", {29'd0, a_iff, a_idf, a_exf}, 32'd7);
    check_eq("br_pc_bub", {30'd0, a_pc, a_bub}, 32'd2);
    tick();
    idle();
    check_eq("br_flush_cnt", {16'd0, a_fcnt}, 32'd1);
    check_eq("br_stall_cnt", {16'd0, a_scnt}, 32'd0);
    check_eq("br_l3_run", {31'd0, b_stl}, 32'd0);

    // Freeze during the second stall cycle, with a branch that must be ignored.
    do_reset();
    drive(5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    check_eq("frz1_ctrl", {28'd0, b_hold, b_pc, b_ifw, b_bub}, 32'd8);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    check_eq("frz2_ctrl", {28'd0, b_hold, b_pc, b_ifw, b_bub}, 32'd8);
    check_eq("frz2_noflush", {29'd0, b_iff, b_idf, b_exf}, 32'd0);
    check_eq("frz2_stalled", {31'd0, b_stl}, 32'd1);
    tick();
    idle();
    check_eq("frz_post1_bub", {31'd0, b_bub}, 32'd1);
    tick();
    check_eq("frz_post2_bub", {31'd0, b_bub}, 32'd1);
    tick();
    check_eq("frz_run_bub", {31'd0, b_bub}, 32'd0);
    check_eq("frz_stall_cnt", {16'd0, b_scnt}, 32'd3);
    check_eq("frz_flush_cnt", {16'd0, b_fcnt}, 32'd0);

    // Saturation of 4-bit counters.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      tick();
      idle();
      tick();
    end
    check_eq("sat_stall_cnt", {28'd0, c_scnt}, 32'd15);
    for (int i = 0; i < 20; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
    end
    idle();
    check_eq("sat_flush_cnt", {28'd0, c_fcnt}, 32'd15);

    // Reset in the middle of a stall.
    do_reset();
    drive(5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    tick();
    check_eq("mid_stalled", {31'd0, b_stl}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_pc", {31'd0, b_pc}, 32'd1);
    tick();
    rst = 1'b0;
    idle();
    check_eq("mid_post_stalled", {31'd0, b_stl}, 32'd0);
    check_eq("mid_post_pc", {31'd0, b_pc}, 32'd1);
    check_eq("mid_post_cnt", {b_scnt, b_fcnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
